// File: rtl/pmem_loader.sv
// Instruction-fetch program memory with a length-prefixed byte-stream boot loader in front.
// Define PMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module pmem_loader #(
   parameter int              ILen      = 32,
   parameter int              AddrWidth = 16,
   parameter int              Depth     = 1024,
   parameter logic [ILen-1:0] NopInstr  = 32'h00000013
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] pmem_addr_i,
   output logic [ILen-1:0]      pmem_rdata_o,
   input  logic [7:0]           ld_data_i,
   input  logic                 ld_valid_i,
   output logic                 ld_ready_o,
   output logic                 core_rst_no,
   output logic                 loaded_o,
   output logic                 err_o
);

   localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

`ifdef PMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {ST_HDR0, ST_HDR1, ST_DATA, ST_RUN, ST_CSUM, ST_ERROR} state_e;
   localparam state_e DoneSt = ST_CSUM;
`else
   typedef enum logic [2:0] {ST_HDR0, ST_HDR1, ST_DATA, ST_RUN} state_e;
   localparam state_e DoneSt = ST_RUN;
`endif

   state_e            state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [15:0]       words_q, words_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [23:0]       word_q, word_d;
   logic              err_q, err_d;
   logic              core_rst_n_q, core_rst_n_d;
   logic              loaded_q, loaded_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic [ILen-1:0]   mem_q [Depth];
   logic              we;
   logic [IdxW-1:0]   wr_idx;
   logic [ILen-1:0]   wr_data;
   logic              ld_fire;
   logic [AddrWidth-3:0] rd_idx;
   logic              unused_addr;

   always_comb begin
      ld_ready_o = 1'b0;
      unique case (state_q)
         ST_HDR0, ST_HDR1, ST_DATA: ld_ready_o = 1'b1;
`ifdef PMEM_LOADER_CHECKSUM_EN
         ST_CSUM:                   ld_ready_o = 1'b1;
`endif
         default:                   ld_ready_o = 1'b0;
      endcase
   end

   assign ld_fire = ld_valid_i & ld_ready_o;
   assign wr_idx  = words_q[IdxW-1:0];

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      words_d = words_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      err_d   = err_q;
      we      = 1'b0;
      wr_data = {ld_data_i, word_q};
`ifdef PMEM_LOADER_CHECKSUM_EN
      csum_d  = ld_fire ? (csum_q ^ ld_data_i) : csum_q;
`endif
      if (ld_fire) begin
         unique case (state_q)
            ST_HDR0: begin
               cnt_d[7:0] = ld_data_i;
               state_d    = ST_HDR1;
            end
            ST_HDR1: begin
               cnt_d[15:8] = ld_data_i;
               words_d     = 16'd0;
               lane_d      = 2'd0;
               state_d     = ({ld_data_i, cnt_q[7:0]} == 16'd0) ? DoneSt : ST_DATA;
            end
            ST_DATA: begin
               lane_d = lane_q + 2'd1;
               unique case (lane_q)
                  2'd0: word_d[7:0]   = ld_data_i;
                  2'd1: word_d[15:8]  = ld_data_i;
                  2'd2: word_d[23:16] = ld_data_i;
                  default: begin
                     // Words past the array end are still consumed so the stream stays aligned.
                     if (32'(words_q) < Depth) we = 1'b1;
                     else                      err_d = 1'b1;
                     words_d = words_q + 16'd1;
                     if (words_q + 16'd1 == cnt_q) state_d = DoneSt;
                  end
               endcase
            end
`ifdef PMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (ld_data_i == csum_q) begin
                  state_d = ST_RUN;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end
            end
`endif
            default: ;
         endcase
      end
      core_rst_n_d = (state_d == ST_RUN);
      loaded_d     = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_HDR0;
         lane_q       <= 2'd0;
         words_q      <= 16'd0;
         cnt_q        <= 16'd0;
         word_q       <= 24'd0;
         err_q        <= 1'b0;
         core_rst_n_q <= 1'b0;
         loaded_q     <= 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
         csum_q       <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         words_q      <= words_d;
         cnt_q        <= cnt_d;
         word_q       <= word_d;
         err_q        <= err_d;
         core_rst_n_q <= core_rst_n_d;
         loaded_q     <= loaded_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (we) mem_q[wr_idx] <= wr_data;
   end

   // Reads only happen in RUN, so they never race a loader write.
   assign rd_idx      = pmem_addr_i[AddrWidth-1:2];
   assign unused_addr = ^pmem_addr_i[1:0];

   always_comb begin
      pmem_rdata_o = NopInstr;
      if (state_q == ST_RUN && 32'(rd_idx) < Depth) pmem_rdata_o = mem_q[rd_idx[IdxW-1:0]];
   end

   assign core_rst_no = core_rst_n_q;
   assign loaded_o    = loaded_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: a Depth=1024 instance and a Depth=4 instance share one byte stream.
module tb_pmem_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] addr = 16'h0;
   logic [7:0]  ld_data = 8'h0;
   logic        ld_valid = 1'b0;

   logic [31:0] rdata_b, rdata_s;
   logic        ready_b, crst_b, loaded_b, err_b;
   logic        ready_s, crst_s, loaded_s, err_s;

   pmem_loader #(.Depth(1024)) u_big (
      .clk_i(clk), .rst_ni(rst_n), .pmem_addr_i(addr), .pmem_rdata_o(rdata_b),
      .ld_data_i(ld_data), .ld_valid_i(ld_valid), .ld_ready_o(ready_b),
      .core_rst_no(crst_b), .loaded_o(loaded_b), .err_o(err_b));

   pmem_loader #(.Depth(4)) u_small (
      .clk_i(clk), .rst_ni(rst_n), .pmem_addr_i(addr), .pmem_rdata_o(rdata_s),
      .ld_data_i(ld_data), .ld_valid_i(ld_valid), .ld_ready_o(ready_s),
      .core_rst_no(crst_s), .loaded_o(loaded_s), .err_o(err_s));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [31:0] exp;
   } vec_t;

   int          pass_cnt = 0;
   int          tot_cnt  = 0;
   logic [31:0] img [1024];
   vec_t        vt [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Caller is at a negedge; returns at a negedge after the byte transferred plus gap idle cycles.
   task automatic send(input logic [7:0] b, input int gap);
      int t = 0;
      ld_data  = b;
      ld_valid = 1'b1;
      while (!ready_b && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         chk("ready_timeout", {31'd0, ready_b}, 32'd1);
         ld_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      ld_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_image(input int n, input int gap, input bit bad);
      logic [7:0] q [$];
      logic [7:0] x;
      logic [31:0] w;
      logic [15:0] nn;
      nn = 16'(n);
      q.push_back(nn[7:0]);
      q.push_back(nn[15:8]);
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
      end
`ifdef PMEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (q[j]) x = x ^ q[j];
      q.push_back(bad ? (x ^ 8'h01) : x);
`else
      x = {7'd0, bad};
`endif
      foreach (q[j]) begin
         if (j == q.size() - 1) chk("crst_before_last", {31'd0, crst_b}, 32'd0);
         send(q[j], gap);
      end
   endtask

   task automatic do_reset();
      ld_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic rd_big(input string name, input logic [15:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(name, rdata_b, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      chk("rst_crst",   {31'd0, crst_b},   32'd0);
      chk("rst_loaded", {31'd0, loaded_b}, 32'd0);
      chk("rst_err",    {31'd0, err_b},    32'd0);
      chk("rst_ready",  {31'd0, ready_b},  32'd1);
      rd_big("preload_fetch", 16'h0000, 32'h00000013);

      // First scenario at full rate
      img[0] = 32'h00100093;
      img[1] = 32'h00200113;
      send_image(2, 0, 1'b0);
      chk("s1_crst",   {31'd0, crst_b},   32'd1);
      chk("s1_loaded", {31'd0, loaded_b}, 32'd1);
      chk("s1_err",    {31'd0, err_b},    32'd0);
      chk("s1_ready",  {31'd0, ready_b},  32'd0);
      rd_big("s1_addr4", 16'h0004, 32'h00200113);
      rd_big("s1_addr0", 16'h0000, 32'h00100093);
      rd_big("s1_addr6", 16'h0006, 32'h00200113);

      // Full 1024-word image, then table-driven fetches incl. range boundaries
      for (int i = 0; i < 1024; i++) img[i] = 32'hA5000000 | i;
      do_reset();
      send_image(1024, 0, 1'b0);
      chk("big_loaded", {31'd0, loaded_b}, 32'd1);
      chk("big_err",    {31'd0, err_b},    32'd0);
      vt[0] = '{16'h0000, 32'hA5000000};
      vt[1] = '{16'h0004, 32'hA5000001};
      vt[2] = '{16'h0008, 32'hA5000002};
      vt[3] = '{16'h0FFC, 32'hA50003FF};
      vt[4] = '{16'h0FFF, 32'hA50003FF};
      vt[5] = '{16'h1000, 32'h00000013};
      vt[6] = '{16'hFFFC, 32'h00000013};
      vt[7] = '{16'h0800, 32'hA5000200};
      for (int i = 0; i < 8; i++) rd_big($sformatf("tbl_%0d", i), vt[i].a, vt[i].exp);

      // Toggling valid, then bytes offered in RUN must be ignored
      img[0] = 32'h00100093;
      img[1] = 32'h00200113;
      do_reset();
      send_image(2, 1, 1'b0);
      ld_data  = 8'hFF;
      ld_valid = 1'b1;
      repeat (6) begin
         chk("run_ready", {31'd0, ready_b}, 32'd0);
         @(negedge clk);
      end
      ld_valid = 1'b0;
      chk("tg_loaded", {31'd0, loaded_b}, 32'd1);
      rd_big("tg_addr0", 16'h0000, 32'h00100093);
      rd_big("tg_addr4", 16'h0004, 32'h00200113);
      rd_big("tg_addr8", 16'h0008, 32'hA5000002);

      // Empty image
      do_reset();
      send_image(0, 0, 1'b0);
      chk("empty_loaded", {31'd0, loaded_b}, 32'd1);
      chk("empty_crst",   {31'd0, crst_b},   32'd1);
      chk("empty_err",    {31'd0, err_b},    32'd0);

      // Overflow on the Depth=4 instance
      for (int i = 0; i < 5; i++) img[i] = 32'hC0DE0000 + i;
      do_reset();
      send_image(5, 0, 1'b0);
      chk("ovf_err",    {31'd0, err_s},    32'd1);
      chk("ovf_loaded", {31'd0, loaded_s}, 32'd1);
      chk("ovf_crst",   {31'd0, crst_s},   32'd1);
      chk("ovf_big_err", {31'd0, err_b},   32'd0);
      for (int i = 0; i < 4; i++) begin
         addr = 16'(i * 4);
         #1;
         chk($sformatf("ovf_w%0d", i), rdata_s, 32'hC0DE0000 + i);
      end
      addr = 16'h0010;
      #1;
      chk("ovf_w4_small", rdata_s, 32'h00000013);
      chk("ovf_w4_big",   rdata_b, 32'hC0DE0004);

      // Reset after 5 bytes, then full reload
      img[0] = 32'h00100093;
      img[1] = 32'h00200113;
      do_reset();
      send(8'h02, 0); chk("abort_crst1", {31'd0, crst_b}, 32'd0);
      send(8'h00, 0); chk("abort_crst2", {31'd0, crst_b}, 32'd0);
      send(8'h93, 0); chk("abort_crst3", {31'd0, crst_b}, 32'd0);
      send(8'h00, 0); chk("abort_crst4", {31'd0, crst_b}, 32'd0);
      send(8'h10, 0); chk("abort_crst5", {31'd0, crst_b}, 32'd0);
      rd_big("abort_fetch", 16'h0000, 32'h00000013);
      rst_n = 1'b0;
      #1;
      chk("abort_rst_crst",  {31'd0, crst_b},  32'd0);
      chk("abort_rst_ready", {31'd0, ready_b}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_image(2, 0, 1'b0);
      chk("reload_loaded", {31'd0, loaded_b}, 32'd1);
      rd_big("reload_addr0", 16'h0000, 32'h00100093);
      rd_big("reload_addr4", 16'h0004, 32'h00200113);

`ifdef PMEM_LOADER_CHECKSUM_EN
      // Wrong checksum byte
      do_reset();
      send_image(2, 0, 1'b1);
      repeat (2) @(negedge clk);
      chk("csum_err",    {31'd0, err_b},    32'd1);
      chk("csum_crst",   {31'd0, crst_b},   32'd0);
      chk("csum_loaded", {31'd0, loaded_b}, 32'd0);
      chk("csum_ready",  {31'd0, ready_b},  32'd0);
      rd_big("csum_fetch", 16'h0000, 32'h00000013);
`endif

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
